// File: rtl/sram_dp_init.sv
// Simple dual-port SRAM (one write port, one read port) with per-byte write
// enables, 1- or 2-cycle read latency, write-first collision forwarding and a
// clear-on-reset sweep that zeroes every word before traffic is accepted.
//
// Optional feature macro: SRAM_PARITY_EN (one even-parity bit per byte, error
// injection on write, parity error flag alongside o_rd_valid).
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   o_ready             high once the init sweep has finished
//   i_wr_en/addr/be/data  write request with per-byte enables
//   i_rd_en/addr        read request
//   o_rd_data/valid     read result and its one-cycle strobe
//   i_parity_inject     (SRAM_PARITY_EN) invert stored parity of written bytes
//   o_parity_err        (SRAM_PARITY_EN) returned word has a parity mismatch
module sram_dp_init #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  output logic                      o_ready,
  input  logic                      i_wr_en,
  input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH/8-1:0]   i_wr_be,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  input  logic                      i_rd_en,
  input  logic [ADDR_WIDTH-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0]     o_rd_data,
  output logic                      o_rd_valid
`ifdef SRAM_PARITY_EN
  ,
  input  logic                      i_parity_inject,
  output logic                      o_parity_err
`endif
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DepthW  = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  logic ready;
  logic wr_fire, rd_fire, rd_in_range;

  assign ready       = (state_q == StRun);
  assign o_ready     = ready;
  assign wr_fire     = ready && i_wr_en && ({1'b0, i_wr_addr} < DepthW);
  assign rd_fire     = ready && i_rd_en;
  assign rd_in_range = ({1'b0, i_rd_addr} < DepthW);

  // Storage is deliberately not reset: the sweep clears it after reset release.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (state_q == StInit) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (i_wr_be[k]) mem_q[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
      end
    end
  end

  // Write-first read word: stored word with this cycle's enabled bytes merged in.
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[i_rd_addr];
      if (wr_fire && (i_wr_addr == i_rd_addr)) begin
        for (int k = 0; k < NumBytes; k++) begin
          if (i_wr_be[k]) rd_word[8*k +: 8] = i_wr_data[8*k +: 8];
        end
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NumBytes-1:0] par_q [DEPTH];
  logic [NumBytes-1:0] rd_par;
  logic                rd_err;

  always_ff @(posedge i_clk) begin
    if (state_q == StInit) begin
      par_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (i_wr_be[k]) par_q[i_wr_addr][k] <= (^i_wr_data[8*k +: 8]) ^ i_parity_inject;
      end
    end
  end

  always_comb begin
    rd_par = '0;
    rd_err = 1'b0;
    if (rd_in_range) begin
      rd_par = par_q[i_rd_addr];
      if (wr_fire && (i_wr_addr == i_rd_addr)) begin
        for (int k = 0; k < NumBytes; k++) begin
          if (i_wr_be[k]) rd_par[k] = (^i_wr_data[8*k +: 8]) ^ i_parity_inject;
        end
      end
      for (int k = 0; k < NumBytes; k++) begin
        if ((^rd_word[8*k +: 8]) != rd_par[k]) rd_err = 1'b1;
      end
    end
  end
`endif

  // Stage 1 snapshots the word at issue, so later writes cannot touch it.
  logic                  p1_valid_q;
  logic [DATA_WIDTH-1:0] p1_data_q;
`ifdef SRAM_PARITY_EN
  logic                  p1_err_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p1_valid_q <= 1'b0;
      p1_data_q  <= '0;
`ifdef SRAM_PARITY_EN
      p1_err_q   <= 1'b0;
`endif
    end else begin
      p1_valid_q <= rd_fire;
      if (rd_fire) p1_data_q <= rd_word;
`ifdef SRAM_PARITY_EN
      p1_err_q   <= rd_fire && rd_err;
`endif
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  p2_valid_q;
    logic [DATA_WIDTH-1:0] p2_data_q;
`ifdef SRAM_PARITY_EN
    logic                  p2_err_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        p2_valid_q <= 1'b0;
        p2_data_q  <= '0;
`ifdef SRAM_PARITY_EN
        p2_err_q   <= 1'b0;
`endif
      end else begin
        p2_valid_q <= p1_valid_q;
        if (p1_valid_q) p2_data_q <= p1_data_q;
`ifdef SRAM_PARITY_EN
        p2_err_q   <= p1_valid_q && p1_err_q;
`endif
      end
    end

    assign o_rd_valid = p2_valid_q;
    assign o_rd_data  = p2_data_q;
`ifdef SRAM_PARITY_EN
    assign o_parity_err = p2_err_q;
`endif
  end else begin : g_lat1
    assign o_rd_valid = p1_valid_q;
    assign o_rd_data  = p1_data_q;
`ifdef SRAM_PARITY_EN
    assign o_parity_err = p1_err_q;
`endif
  end

endmodule

// File: tb/tb_sram_dp_init.sv
// Bench for sram_dp_init: two instances in lockstep (6-bit address with
// latency 1, 7-bit address with latency 2) against an array/queue model.
module tb_sram_dp_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, inject = 1'b0;
  logic [6:0]  wr_addr = '0, rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;

  logic        rdy1, rdy2, vld1, vld2;
  logic [31:0] rdata1, rdata2;
`ifdef SRAM_PARITY_EN
  logic        perr1, perr2;
`endif

  sram_dp_init #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(64), .READ_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy1),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr[5:0]), .i_wr_be(wr_be), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr[5:0]), .o_rd_data(rdata1), .o_rd_valid(vld1)
`ifdef SRAM_PARITY_EN
    , .i_parity_inject(inject), .o_parity_err(perr1)
`endif
  );

  sram_dp_init #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .DEPTH(64), .READ_LATENCY(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy2),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_be(wr_be), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rdata2), .o_rd_valid(vld2)
`ifdef SRAM_PARITY_EN
    , .i_parity_inject(inject), .o_parity_err(perr2)
`endif
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q1[$], q2[$];
  logic [31:0] mem_m [2][64];
  logic [3:0]  cor_m [2][64];  // bytes whose stored parity was inverted
  logic [31:0] last1, last2;
  int          since;          // cycles since reset release
  int          checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 64; a++) begin
        mem_m[d][a] = '0;
        cor_m[d][a] = '0;
      end
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
  endtask

  task automatic check_outputs();
    check("ready1", 32'(rdy1), 32'(since >= 64));
    check("ready2", 32'(rdy2), 32'(since >= 64));
    if (q1.size() > 0 && q1[0].due == since) begin
      check("valid1", 32'(vld1), 32'd1);
      check("data1", rdata1, q1[0].data);
`ifdef SRAM_PARITY_EN
      check("perr1", 32'(perr1), 32'(q1[0].err));
`endif
      last1 = q1[0].data;
      void'(q1.pop_front());
    end else begin
      check("idle_valid1", 32'(vld1), 32'd0);
      check("hold_data1", rdata1, last1);
    end
    if (q2.size() > 0 && q2[0].due == since) begin
      check("valid2", 32'(vld2), 32'd1);
      check("data2", rdata2, q2[0].data);
`ifdef SRAM_PARITY_EN
      check("perr2", 32'(perr2), 32'(q2[0].err));
`endif
      last2 = q2[0].data;
      void'(q2.pop_front());
    end else begin
      check("idle_valid2", 32'(vld2), 32'd0);
      check("hold_data2", rdata2, last2);
    end
  endtask

  // One clock cycle with the given requests; model updated at the edge.
  task automatic step(input logic we, input logic [6:0] wa, input logic [3:0] be,
                      input logic [31:0] wd, input logic inj,
                      input logic re, input logic [6:0] ra);
    logic        rdy;
    logic [6:0]  a, w;
    logic [31:0] word;
    logic [3:0]  cor;
    exp_t        e;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; inject = inj;
    rd_en = re; rd_addr = ra;
    @(posedge clk);
    rdy = (since >= 64);
    for (int d = 0; d < 2; d++) begin
      a = (d == 1) ? ra : {1'b0, ra[5:0]};
      w = (d == 1) ? wa : {1'b0, wa[5:0]};
      if (rdy && re) begin
        word = '0;
        cor  = '0;
        if (a < 64) begin
          word = mem_m[d][a[5:0]];
          cor  = cor_m[d][a[5:0]];
          if (we && w == a)
            for (int k = 0; k < 4; k++)
              if (be[k]) begin
                word[8*k +: 8] = wd[8*k +: 8];
                cor[k] = inj;
              end
        end
        e.due  = since + d + 1;
        e.data = word;
        e.err  = |cor;
        if (d == 0) q1.push_back(e);
        else q2.push_back(e);
      end
      if (rdy && we && w < 64)
        for (int k = 0; k < 4; k++)
          if (be[k]) begin
            mem_m[d][w[5:0]][8*k +: 8] = wd[8*k +: 8];
            cor_m[d][w[5:0]][k] = inj;
          end
    end
    since++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Called #1 after a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    model_clear();
    check("rst_valid1", 32'(vld1), 32'd0);
    check("rst_valid2", 32'(vld2), 32'd0);
    check("rst_data1", rdata1, 32'd0);
    check("rst_data2", rdata2, 32'd0);
    check("rst_ready1", 32'(rdy1), 32'd0);
    check("rst_ready2", 32'(rdy2), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    since = 0;
  endtask

  initial begin
    since = 0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Requests during INIT are ignored; ready is checked low for 64 cycles.
    for (int i = 0; i < 64; i++) begin
      if (i % 9 == 2) step(1'b1, 7'd3, 4'hF, $urandom, 1'b0, 1'b1, 7'd3);
      else idle(1);
    end

    // Whole array reads zero after the sweep, plus out-of-range 64 on dut2.
    for (int a = 0; a < 65; a++) step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'(a));
    idle(3);

    // Byte-enable merge.
    step(1'b1, 7'd5, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, '0);
    step(1'b1, 7'd5, 4'b0101, 32'h11223344, 1'b0, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd5);
    idle(3);

    // Write-first collision, later write must not alter the in-flight result.
    step(1'b1, 7'd9, 4'b1111, 32'h01020304, 1'b0, 1'b0, '0);
    step(1'b1, 7'd9, 4'b1100, 32'hCAFEF00D, 1'b0, 1'b1, 7'd9);
    step(1'b1, 7'd9, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
    idle(3);

    // Back-to-back reads.
    step(1'b1, 7'd1, 4'hF, 32'h0000_0101, 1'b0, 1'b0, '0);
    step(1'b1, 7'd2, 4'hF, 32'h0000_0202, 1'b0, 1'b0, '0);
    step(1'b1, 7'd3, 4'hF, 32'h0000_0303, 1'b0, 1'b1, 7'd1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd2);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd3);
    idle(3);

`ifdef SRAM_PARITY_EN
    step(1'b1, 7'd3, 4'b0001, 32'h000000FF, 1'b1, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd3);
    step(1'b1, 7'd4, 4'b1111, 32'h12345678, 1'b0, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd4);
    step(1'b1, 7'd6, 4'b0010, 32'h0000AA00, 1'b1, 1'b1, 7'd6);
    idle(3);
`endif

    // Random traffic including out-of-range addresses and collisions.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] wa;
      logic [6:0] ra;
      wa = 7'($urandom_range(0, 69));
      ra = ($urandom_range(0, 3) == 0) ? wa : 7'($urandom_range(0, 69));
      step(1'($urandom), wa, 4'($urandom), $urandom, ($urandom_range(0, 7) == 0),
           1'($urandom), ra);
    end
    idle(3);

    // Reset with a read in flight, then reset again 20 cycles into the sweep.
    step(1'b1, 7'd7, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd7);
    do_reset();
    idle(20);
    do_reset();
    idle(64);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd7);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 7'd64);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_dp_init.md
Name: sram_dp_init

Overview:
Simple dual-port SRAM (one write port, one read port) for the BDD accelerator node/table storage. It is the parametrised successor to the single-port scratch SRAM:
- independent read and write ports
- per-byte write enables
- configurable read latency with a valid strobe
- write-first collision forwarding
- hardware clear-on-reset sweep that zeroes the array before the block accepts traffic

Parameters:
ADDR_WIDTH, 6, address bits on both ports
DATA_WIDTH, 32, word width; must be a multiple of 8; NUM_BYTES = DATA_WIDTH/8
DEPTH, 64, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from accepted read to o_rd_valid; legal values 1 or 2

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
o_ready  output  1  high once the init sweep completes; requests are accepted only while high
i_wr_en  input  1  write request
i_wr_addr  input  ADDR_WIDTH  write address
i_wr_be  input  NUM_BYTES  byte enables; bit k covers data[8k+7:8k]
i_wr_data  input  DATA_WIDTH  write data
i_rd_en  input  1  read request
i_rd_addr  input  ADDR_WIDTH  read address
o_rd_data  output  DATA_WIDTH  read data, qualified by o_rd_valid
o_rd_valid  output  1  one-cycle strobe per accepted read

Behaviour:
- Reset (asynchronous assert, synchronous to i_clk on release):
  - o_ready=0, o_rd_valid=0, o_rd_data=0, read pipeline cleared.
  - FSM enters INIT with sweep counter=0.
  - Array contents are not reset directly; the sweep clears them.
- FSM INIT:
  - Each cycle writes 0 (all bytes) to mem[cnt], then cnt++.
  - When cnt==DEPTH-1 is written, the next state is RUN.
  - o_ready rises on the first RUN cycle. INIT lasts exactly DEPTH cycles after reset release.
- FSM RUN: the FSM stays in RUN until reset; there is no other exit.
- Requests while o_ready=0: i_wr_en and i_rd_en are ignored. No array write and no o_rd_valid.
- Write (RUN, i_wr_en=1, i_wr_addr<DEPTH):
  - Bytes with i_wr_be[k]=1 are updated at the clock edge; other bytes are unchanged.
  - be=0 is a legal no-op.
- Read (RUN, i_rd_en=1) accepted in cycle N:
  - o_rd_valid=1 and o_rd_data valid in cycle N+READ_LATENCY.
  - Back-to-back reads give one result per cycle in issue order; full throughput.
  - o_rd_valid is low on all other cycles.
  - o_rd_data holds its last value when o_rd_valid=0.
- Collision (write and read to the same address in the same cycle): write-first.
  - Returned data is the stored word with enabled bytes replaced by i_wr_data bytes.
  - Returned data reflects exactly the writes accepted up to and including the read's issue cycle. Writes in later cycles never alter an in-flight read result, including for READ_LATENCY=2.
- Out-of-range addresses (>= DEPTH):
  - Writes are dropped.
  - Reads still produce o_rd_valid, with o_rd_data=0.
- Reset mid-operation:
  - In-flight reads are discarded (no valid).
  - The sweep restarts from cnt=0, even if reset interrupts INIT.

Optional Feature:
SRAM_PARITY_EN.
- Defined:
  - The array stores one even-parity bit per byte.
  - Adds input i_parity_inject (1 bit): when high with an accepted write, the stored parity of each enabled byte is inverted.
  - Adds output o_parity_err (1 bit, reset 0): asserted in the same cycle as o_rd_valid if any returned byte's parity mismatches.
  - The init sweep writes parity 0.
  - Forwarded collision bytes use freshly computed parity, with inversion applied if i_parity_inject is high.
  - Out-of-range reads report no error.
- Undefined: no parity storage, no extra ports, behaviour otherwise identical.

Test Plan:
- Reset release, DEPTH=64 -> o_ready low for exactly 64 cycles then high; reads of addresses 0..63 all return 0x00000000.
- Write addr 5 = 0xDEADBEEF be=4'b1111, then write addr 5 = 0x11223344 be=4'b0101, read addr 5 -> 0xDE22BE44, with o_rd_valid exactly READ_LATENCY cycles after issue (run with READ_LATENCY=1 and 2).
- Same-cycle write addr 9 = 0xCAFEF00D be=4'b1100 over stored 0x01020304, plus read addr 9 -> 0xCAFE0304; a write of 0xFFFFFFFF to addr 9 in the following cycle does not alter that result (READ_LATENCY=2).
- Back-to-back reads of addrs 1,2,3 over 3 cycles -> three consecutive valid strobes in order; i_wr_en/i_rd_en pulsed during INIT -> no valid and no array change.
- Reset asserted at cycle 20 of the sweep and after writing addr 7 = 0xA5A5A5A5 -> o_rd_valid drops immediately, 64-cycle sweep restarts, addr 7 reads 0 afterwards; read addr 64 (ADDR_WIDTH=7) -> valid with data 0.
- SRAM_PARITY_EN: write addr 3 = 0x000000FF be=4'b0001 with i_parity_inject=1, read addr 3 -> o_parity_err=1; write addr 4 without inject, read addr 4 -> o_parity_err=0.
